// File: rtl/mesh_in_port.sv
// mesh_in_port: mesh router input port. It holds a 2-entry FIFO of flits and
// computes each flit's XY output route when the flit is enqueued.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   reset     synchronous, active-high reset
//   in_valid  upstream offers a flit this cycle
//   in_ready  port can accept a flit (registered state only, count != 2)
//   in_data   incoming flit; dest_x = [49:48], dest_y = [51:50]
//   req       one-hot output request for the head flit: {L, W, E, S, N}
//   gnt       OR of grants from the output arbiters; pops the head flit
//   out_data  head flit, valid whenever req is nonzero
//   count     occupancy 0..2
//   err_gnt   sticky: grant seen while the queue was empty
module mesh_in_port #(
  parameter int unsigned DW   = 64,
  parameter int unsigned MY_X = 0,
  parameter int unsigned MY_Y = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [4:0]    req,
  input  logic          gnt,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count,
  output logic          err_gnt
);

  localparam logic [1:0] MyX = 2'(MY_X);
  localparam logic [1:0] MyY = 2'(MY_Y);

  localparam logic [4:0] RouteN = 5'b00001;
  localparam logic [4:0] RouteS = 5'b00010;
  localparam logic [4:0] RouteE = 5'b00100;
  localparam logic [4:0] RouteW = 5'b01000;
  localparam logic [4:0] RouteL = 5'b10000;

  logic [DW-1:0] data_q  [2];
  logic [4:0]    route_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          err_q;

  logic [1:0] dest_x, dest_y;
  logic [4:0] route_d;
  logic       push, pop;

  assign dest_x = in_data[49:48];
  assign dest_y = in_data[51:50];

  // XY dimension-order routing: resolve X first, then Y, then eject locally.
  always_comb begin
    route_d = RouteL;
    if (dest_x > MyX) begin
      route_d = RouteE;
    end else if (dest_x < MyX) begin
      route_d = RouteW;
    end else if (dest_y > MyY) begin
      route_d = RouteN;
    end else if (dest_y < MyY) begin
      route_d = RouteS;
    end
  end

  // in_ready comes from registered count only, so a pop cannot free a slot
  // for a push in the same cycle while full.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready && !reset;
  assign pop      = gnt && (count_q != 2'd0) && !reset;

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]  <= in_data;
      route_q[wr_ptr_q] <= route_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (gnt && (count_q == 2'd0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req      = (count_q != 2'd0) ? route_q[rd_ptr_q] : 5'b00000;
  assign out_data = data_q[rd_ptr_q];
  assign count    = count_q;
  assign err_gnt  = err_q;

endmodule

// File: tb/tb_mesh_in_port.sv
// Bench for mesh_in_port with MY_X=1, MY_Y=1. Stimulus pushes expected
// {flit, route} entries into a scoreboard queue as flits are accepted; a
// negedge monitor tracks an occupancy model and compares every popped head.
module tb_mesh_in_port;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          gnt = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [4:0]    req;
  logic [DW-1:0] out_data;
  logic [1:0]    count;
  logic          err_gnt;

  mesh_in_port #(
    .DW  (DW),
    .MY_X(1),
    .MY_Y(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .req     (req),
    .gnt     (gnt),
    .out_data(out_data),
    .count   (count),
    .err_gnt (err_gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [4:0]    r;
  } ent_t;

  ent_t       sb[$];
  logic [4:0] exp_route = 5'b0;
  int         checks = 0;
  int         failures = 0;
  int         mcount = 0;
  logic       merr = 1'b0;
  int         pushed = 0;
  int         flushed = 0;
  int         delivered = 0;
  int         tag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: decides what happens at the coming edge from its own model.
  always @(negedge clk) begin
    bit   p, q;
    ent_t e;
    if (reset) begin
      flushed += sb.size();
      sb.delete();
      mcount = 0;
      merr   = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(mcount != 2));
      chk("count", 64'(count), 64'(mcount));
      chk("err_gnt", 64'(err_gnt), 64'(merr));
      chk("req_onehot0", 64'($onehot0(req)), 64'd1);
      if (mcount == 0) chk("req_empty", 64'(req), 64'd0);
      p = in_valid && (mcount != 2);
      q = gnt && (mcount != 0);
      if (q) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("pop_data", out_data, e.d);
          chk("pop_route", 64'(req), 64'(e.r));
          delivered++;
        end
      end
      if (gnt && mcount == 0) merr = 1'b1;
      if (p) begin
        sb.push_back({in_data, exp_route});
        pushed++;
      end
      mcount = mcount + int'(p) - int'(q);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic logic [4:0] route_of(input logic [1:0] dx, input logic [1:0] dy);
    if (dx > 2'd1) return 5'b00100;
    if (dx < 2'd1) return 5'b01000;
    if (dy > 2'd1) return 5'b00001;
    if (dy < 2'd1) return 5'b00010;
    return 5'b10000;
  endfunction

  // Sets up a flit offer; the route is supplied by the caller.
  task automatic offer(input logic [1:0] dx, input logic [1:0] dy, input logic [4:0] r);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[51:50] = dy;
    d[49:48] = dx;
    d[15:0]  = 16'(tag);
    tag++;
    in_data   = d;
    exp_route = r;
    in_valid  = 1'b1;
  endtask

  logic [1:0]    xs[5] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd1};
  logic [1:0]    ys[5] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [4:0]    rs[5] = '{5'b00100, 5'b01000, 5'b00001, 5'b00010, 5'b10000};
  logic [DW-1:0] flit_b, flit_c;

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    at_neg();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_req", 64'(req), 64'd0);
    cyc();

    // One flit at a time through each direction.
    for (int i = 0; i < 5; i++) begin
      offer(xs[i], ys[i], rs[i]);
      cyc();
      in_valid = 1'b0;
      gnt      = 1'b1;
      at_neg();
      chk($sformatf("route_%0d", i), 64'(req), 64'(rs[i]));
      cyc();
      gnt = 1'b0;
    end

    // Fill, refuse a third flit even with a same-cycle grant.
    offer(2'd3, 2'd0, 5'b00100);
    cyc();
    offer(2'd0, 2'd3, 5'b01000);
    flit_b = in_data;
    cyc();
    offer(2'd1, 2'd1, 5'b10000);
    at_neg();
    chk("full_count", 64'(count), 64'd2);
    chk("full_ready", 64'(in_ready), 64'd0);
    cyc();
    gnt = 1'b1;
    cyc();
    gnt      = 1'b0;
    in_valid = 1'b0;
    at_neg();
    chk("after_pop_data", out_data, flit_b);
    chk("after_pop_count", 64'(count), 64'd1);
    chk("after_pop_ready", 64'(in_ready), 64'd1);
    cyc();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;

    // Simultaneous push and pop with one entry held.
    offer(2'd3, 2'd0, 5'b00100);
    cyc();
    offer(2'd1, 2'd3, 5'b00001);
    flit_c = in_data;
    gnt    = 1'b1;
    cyc();
    in_valid = 1'b0;
    gnt      = 1'b0;
    at_neg();
    chk("pp_count", 64'(count), 64'd1);
    chk("pp_data", out_data, flit_c);
    chk("pp_req", 64'(req), 64'b00001);
    cyc();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;

    // Grant while empty sets the sticky error.
    at_neg();
    chk("pre_err", 64'(err_gnt), 64'd0);
    cyc();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    at_neg();
    chk("err_set", 64'(err_gnt), 64'd1);
    chk("err_count", 64'(count), 64'd0);
    chk("err_req", 64'(req), 64'd0);
    cyc();
    cyc();
    cyc();
    at_neg();
    chk("err_sticky", 64'(err_gnt), 64'd1);
    cyc();

    // Reset while full with valid and grant asserted.
    offer(2'd0, 2'd0, 5'b01000);
    cyc();
    offer(2'd2, 2'd2, 5'b00100);
    cyc();
    reset = 1'b1;
    gnt   = 1'b1;
    cyc();
    reset    = 1'b0;
    in_valid = 1'b0;
    gnt      = 1'b0;
    at_neg();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_err", 64'(err_gnt), 64'd0);
    cyc();

    // Random stream with random valid and grant.
    begin
      bit          have = 1'b0;
      int          n = 0;
      int          budget = 20000;
      logic [1:0]  dx, dy;
      while (n < 1000 && budget > 0) begin
        if (!have) begin
          dx = 2'($urandom);
          dy = 2'($urandom);
          offer(dx, dy, route_of(dx, dy));
          have = 1'b1;
        end
        in_valid = 1'($urandom_range(0, 1));
        gnt      = ($urandom_range(0, 9) < 6);
        at_neg();
        if (in_valid && in_ready) begin
          have = 1'b0;
          n++;
        end
        cyc();
        budget--;
      end
      chk("random_accepted", 64'(n), 64'd1000);
    end

    in_valid = 1'b0;
    gnt      = 1'b1;
    for (int i = 0; i < 8 && mcount != 0; i++) cyc();
    gnt = 1'b0;
    at_neg();
    chk("drain_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("delivered", 64'(delivered), 64'(pushed - flushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_in_port.md
MESH_IN_PORT -- requirements
Module: mesh_in_port

Interface
REQ-001 Parameter: DW, 64, flit width in bits.
REQ-002 Parameter: MY_X, 0, 2-bit X coordinate of this router.
REQ-003 Parameter: MY_Y, 0, 2-bit Y coordinate of this router.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers a flit this cycle.
REQ-007 in_ready  output  1  port can accept a flit this cycle.
REQ-008 in_data  input  DW  incoming flit; dest_x = in_data[49:48], dest_y = in_data[51:50].
REQ-009 req  output  5  one-hot output-port request to the output arbiters: bit0 N, bit1 S, bit2 E, bit3 W, bit4 L (local).
REQ-010 gnt  input  1  OR of this port's grant bits from all output arbiters; head flit is consumed this cycle.
REQ-011 out_data  output  DW  head-of-queue flit, valid whenever req is nonzero.
REQ-012 count  output  2  current occupancy, 0..2.
REQ-013 err_gnt  output  1  sticky flag: grant received while queue empty.

Function
REQ-014 The block SHALL implement a 2-entry FIFO of {flit, 5-bit route}.
REQ-015 The route SHALL be computed at enqueue, using XY order: dest_x>MY_X -> E; dest_x<MY_X -> W; else dest_y>MY_Y -> N; dest_y<MY_Y -> S; else L.
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready.
REQ-017 in_ready SHALL equal (count != 2) and SHALL depend only on registered state, not on gnt.
REQ-018 When full, a same-cycle gnt SHALL NOT enable a push; in_ready becomes 1 the cycle after the pop.
REQ-019 req SHALL equal the stored route of the head entry when count>0, and SHALL be 5'b0 when count==0.
REQ-020 out_data SHALL equal the stored head flit when count>0; its value is don't-care when count==0.
REQ-021 Pop SHALL occur on a rising edge when gnt && count>0; the head advances and count decrements.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, with the new flit placed behind the remaining entry.
REQ-023 Latency: a flit pushed into an empty queue SHALL drive req/out_data in the next cycle (1-cycle latency). No bypass path is permitted.
REQ-024 Order SHALL be strictly FIFO; flits are never reordered or dropped.
REQ-025 A gnt arriving with count==0 SHALL be ignored for data purposes and SHALL set err_gnt, which holds until reset.
REQ-026 Read and write pointers SHALL be 1 bit each and wrap modulo 2; count SHALL saturate at neither bound, because the handshake rules prevent overflow and underflow.
REQ-027 req SHALL be one-hot or zero in every cycle.

Reset
REQ-028 While reset is high at a rising edge: count=0, pointers=0, err_gnt=0; therefore req=0 and in_ready=1 in the following cycle.
REQ-029 Reset asserted mid-operation SHALL discard all buffered flits; push and gnt in that cycle are ignored.
REQ-030 Storage arrays SHALL NOT require a reset.

Verification
REQ-031 MY_X=1, MY_Y=1; push flits with dest (2,1), (0,1), (1,2), (1,0), (1,1) one at a time, each granted -> req = 00100, 01000, 00001, 00010, 10000 respectively.
REQ-032 Push A, B with gnt held 0 -> count=2, in_ready=0; a third in_valid is not accepted; gnt for 1 cycle -> out_data=B, count=1, in_ready=1 the next cycle.
REQ-033 count=1 holding A; push C with gnt=1 in the same cycle -> next cycle count=1, out_data=C, req=route(C).
REQ-034 Empty queue; gnt=1 for 1 cycle -> err_gnt=1, count stays 0, req=0; err_gnt stays 1 until reset.
REQ-035 count=2 with err_gnt=1; assert reset for 1 cycle while in_valid=1 and gnt=1 -> next cycle count=0, req=0, in_ready=1, err_gnt=0.
REQ-036 Random stream of 1000 flits with random in_valid/gnt -> scoreboard shows every flit delivered in order with the correct route, and req is never non-one-hot.
